// File: rtl/seq_mag_compare_pkg.sv
// ---------------------------------------------------------------------------
// seq_mag_compare_pkg
// Shared definitions for the sequential magnitude comparator:
//   - 3-bit result codes, packed as {gt, lt, eq}
//   - FSM state encoding used by the top level
// Imported by the comparator top level and by chunk_compare.
// ---------------------------------------------------------------------------
package seq_mag_compare_pkg;

  localparam int RES_W = 3;

  typedef logic [RES_W-1:0] result_t;

  localparam result_t RES_GT   = 3'b100;
  localparam result_t RES_LT   = 3'b010;
  localparam result_t RES_EQ   = 3'b001;
  localparam result_t RES_NONE = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Width of a chunk index able to address nChunk chunks (at least 1 bit).
  function automatic int idxWidth(input int nChunk);
    return (nChunk > 1) ? $clog2(nChunk) : 1;
  endfunction

endpackage

// File: rtl/seq_mag_compare_if.sv
// ---------------------------------------------------------------------------
// seq_mag_compare_if
// Request/response bundle of the sequential magnitude comparator.
//   start    : request, sampled only while the comparator is idle
//   iSigned  : 1 = two's-complement compare, 0 = unsigned
//   iData_a  : operand A
//   iData_b  : operand B
//   iData    : cascade-in {gt,lt,eq}, reported when A == B
//   busy     : compare in progress
//   done     : one-cycle result strobe
//   oData    : result {gt,lt,eq}
// master drives the request side, slave (the comparator) drives the response.
// ---------------------------------------------------------------------------
interface seq_mag_compare_if #(
  parameter int DATA_W = 16
);

  logic              start;
  logic              iSigned;
  logic [DATA_W-1:0] iData_a;
  logic [DATA_W-1:0] iData_b;
  logic [2:0]        iData;
  logic              busy;
  logic              done;
  logic [2:0]        oData;

  modport master (
    output start,
    output iSigned,
    output iData_a,
    output iData_b,
    output iData,
    input  busy,
    input  done,
    input  oData
  );

  modport slave (
    input  start,
    input  iSigned,
    input  iData_a,
    input  iData_b,
    input  iData,
    output busy,
    output done,
    output oData
  );

endinterface

// File: rtl/seq_mag_compare_chunk_compare.sv
// ---------------------------------------------------------------------------
// chunk_compare
// Purely combinational CHUNK_W-bit unsigned magnitude compare.
//   chunkA  : left operand chunk
//   chunkB  : right operand chunk
//   result  : {gt,lt,eq}, exactly one bit set
// Signed handling is done by the caller (sign bit inversion on the top
// chunk), so this block only ever sees unsigned values.
// ---------------------------------------------------------------------------
module chunk_compare
  import seq_mag_compare_pkg::*;
#(
  parameter int CHUNK_W = 4
) (
  input  logic [CHUNK_W-1:0] chunkA,
  input  logic [CHUNK_W-1:0] chunkB,
  output result_t            result
);

  always_comb begin
    result = RES_EQ;
    if (chunkA > chunkB) begin
      result = RES_GT;
    end else if (chunkA < chunkB) begin
      result = RES_LT;
    end
  end

endmodule

// File: rtl/seq_mag_compare.sv
// ---------------------------------------------------------------------------
// seq_mag_compare
// Sequential magnitude comparator: compares two DATA_W-bit operands one
// CHUNK_W-bit chunk per clock, most significant chunk first, and stops at
// the first chunk that differs. When all chunks match, the latched
// cascade-in code is reported unchanged.
//
// Ports:
//   clk  : clock, rising-edge active
//   rst  : synchronous active-high reset
//   bus  : seq_mag_compare_if.slave (start/iSigned/iData_a/iData_b/iData in,
//          busy/done/oData out)
//
// Latency: done rises k cycles after the edge that accepts start, where k is
// the number of chunks examined (1..NCHUNK). start is accepted in the same
// cycle done is high, so transactions can run back to back.
// ---------------------------------------------------------------------------
module seq_mag_compare
  import seq_mag_compare_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  seq_mag_compare_if.slave bus
);

  localparam int NCHUNK = DATA_W / CHUNK_W;
  localparam int IDX_W  = idxWidth(NCHUNK);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [IDX_W-1:0]   ZERO_IDX = '0;
  localparam logic [CHUNK_W-1:0] MSB_MASK = CHUNK_W'(1) << (CHUNK_W - 1);

  if ((CHUNK_W < 1) || (DATA_W < CHUNK_W) || ((DATA_W % CHUNK_W) != 0)) begin : gBadWidth
    $error("seq_mag_compare: DATA_W must be a positive multiple of CHUNK_W");
  end

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic [NCHUNK-1:0][CHUNK_W-1:0]  opA;
  logic [NCHUNK-1:0][CHUNK_W-1:0]  opB;
  logic                            sgnMode;
  result_t                         cascIn;

  logic                            busyR;
  logic                            doneR;
  result_t                         outR;

  logic [CHUNK_W-1:0]              signFlip;
  logic [CHUNK_W-1:0]              chunkA;
  logic [CHUNK_W-1:0]              chunkB;
  result_t                         chunkRes;

  // Signed compare reduces to unsigned compare once the sign bit of the
  // top chunk is inverted on both sides (offset-binary mapping). Lower
  // chunks carry plain magnitude bits and need no adjustment.
  always_comb begin
    signFlip = '0;
    if (sgnMode && (idx == LAST_IDX)) begin
      signFlip = MSB_MASK;
    end
    chunkA = opA[idx] ^ signFlip;
    chunkB = opB[idx] ^ signFlip;
  end

  chunk_compare #(
    .CHUNK_W (CHUNK_W)
  ) uChunkCmp (
    .chunkA (chunkA),
    .chunkB (chunkB),
    .result (chunkRes)
  );

  // Control FSM. Operand/cascade registers only load on an accepted start
  // and are don't-care otherwise, so they are left out of the reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
      busyR <= 1'b0;
      doneR <= 1'b0;
      outR  <= RES_NONE;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            opA     <= bus.iData_a;
            opB     <= bus.iData_b;
            sgnMode <= bus.iSigned;
            cascIn  <= bus.iData;
            idx     <= LAST_IDX;
            busyR   <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (chunkRes != RES_EQ) begin
            // First differing chunk decides the result.
            outR  <= (chunkRes == RES_GT) ? RES_GT : RES_LT;
            doneR <= 1'b1;
            busyR <= 1'b0;
            state <= IDLE;
          end else if (idx == ZERO_IDX) begin
            // Operands equal: pass the cascade-in through untouched.
            outR  <= cascIn;
            doneR <= 1'b1;
            busyR <= 1'b0;
            state <= IDLE;
          end else begin
            idx <= idx - 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busyR <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy  = busyR;
  assign bus.done  = doneR;
  assign bus.oData = outR;

endmodule

// File: tb/tb_seq_mag_compare.sv
// ---------------------------------------------------------------------------
// tb_seq_mag_compare
// Bench for seq_mag_compare (DATA_W=16, CHUNK_W=4). A transaction-level
// model derives the result and latency of each accepted request from the
// operand values with plain arithmetic; a per-cycle process compares the
// DUT's busy/done/oData against it. Directed scenarios add literal checks.
// ---------------------------------------------------------------------------
module tb_seq_mag_compare;

  localparam int DATA_W  = 16;
  localparam int CHUNK_W = 4;
  localparam int NCHUNK  = DATA_W / CHUNK_W;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;
  bit chkEn  = 1'b0;

  seq_mag_compare_if #(.DATA_W(DATA_W)) bus ();

  seq_mag_compare #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result and number of chunks examined, straight from the operand values.
  function automatic void modelCompute(input logic [15:0] a, input logic [15:0] b,
                                       input logic sgn, input logic [2:0] casc,
                                       output logic [2:0] res, output int k);
    logic [15:0]        diff;
    logic signed [15:0] sa;
    logic signed [15:0] sb;
    bit                 gt;
    int                 top;
    diff = a ^ b;
    sa   = a;
    sb   = b;
    if (diff == 16'h0) begin
      res = casc;
      k   = NCHUNK;
    end else begin
      top = 0;
      for (int i = 0; i < DATA_W; i++) begin
        if (diff[i]) top = i;
      end
      k  = NCHUNK - (top / CHUNK_W);
      gt = sgn ? (sa > sb) : (a > b);
      res = gt ? 3'b100 : 3'b010;
    end
  endfunction

  // Model state
  bit         mBusy = 1'b0;
  bit         mDone = 1'b0;
  logic [2:0] mOut  = 3'b000;
  logic [2:0] mRes  = 3'b000;
  int         mCnt  = 0;

  always @(posedge clk) begin
    if (rst) begin
      mBusy = 1'b0;
      mDone = 1'b0;
      mOut  = 3'b000;
      mCnt  = 0;
    end else begin
      mDone = 1'b0;
      if (mBusy) begin
        mCnt--;
        if (mCnt == 0) begin
          mBusy = 1'b0;
          mDone = 1'b1;
          mOut  = mRes;
        end
      end else if (bus.start) begin
        modelCompute(bus.iData_a, bus.iData_b, bus.iSigned, bus.iData, mRes, mCnt);
        mBusy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("cyc busy",  32'(bus.busy),  32'(mBusy));
      check("cyc done",  32'(bus.done),  32'(mDone));
      check("cyc oData", 32'(bus.oData), 32'(mOut));
      check("cyc busy&done", 32'(bus.busy & bus.done), 32'd0);
    end
  end

  task automatic driveReq(input logic [15:0] a, input logic [15:0] b,
                          input logic sgn, input logic [2:0] casc);
    bus.start   = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    bus.iSigned = sgn;
    bus.iData   = casc;
  endtask

  // After start has been sampled: scramble inputs, wait for done, return latency.
  task automatic waitDone(input string name, output int lat);
    bus.start   = 1'b0;
    bus.iData_a = 16'($urandom);
    bus.iData_b = 16'($urandom);
    bus.iSigned = 1'($urandom);
    bus.iData   = 3'($urandom);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check({name, " timeout"}, 32'(lat), 32'd0);
  endtask

  task automatic runOne(input string name, input logic [15:0] a, input logic [15:0] b,
                        input logic sgn, input logic [2:0] casc,
                        input logic [2:0] expOut, input int expLat);
    int lat;
    @(negedge clk);
    driveReq(a, b, sgn, casc);
    @(negedge clk);
    waitDone(name, lat);
    check({name, " lat"}, 32'(lat), 32'(expLat));
    check({name, " out"}, 32'(bus.oData), 32'(expOut));
  endtask

  initial begin
    logic [2:0] r;
    int         k;
    int         lat;
    int         nd;

    rst = 1'b1;
    bus.start = 1'b0; bus.iSigned = 1'b0;
    bus.iData_a = '0; bus.iData_b = '0; bus.iData = '0;

    // Pin the model against hand-computed values.
    modelCompute(16'h8000, 16'h7FFF, 1'b1, 3'b001, r, k);
    check("model 8000s res", 32'(r), 32'h2);
    check("model 8000s k",   32'(k), 32'd1);
    modelCompute(16'h0001, 16'h0002, 1'b0, 3'b001, r, k);
    check("model 1v2 k", 32'(k), 32'd4);

    @(negedge clk);
    @(negedge clk);
    check("reset busy",  32'(bus.busy),  32'd0);
    check("reset done",  32'(bus.done),  32'd0);
    check("reset oData", 32'(bus.oData), 32'd0);
    chkEn = 1'b1;
    rst = 1'b0;

    runOne("eq casc001",  16'h1234, 16'h1234, 1'b0, 3'b001, 3'b001, 4);
    runOne("eq casc100",  16'h1234, 16'h1234, 1'b0, 3'b100, 3'b100, 4);
    runOne("8000u",       16'h8000, 16'h7FFF, 1'b0, 3'b001, 3'b100, 1);
    runOne("8000s",       16'h8000, 16'h7FFF, 1'b1, 3'b001, 3'b010, 1);
    runOne("m1 vs m2 s",  16'hFFFF, 16'hFFFE, 1'b1, 3'b001, 3'b100, 4);
    runOne("1234v1235",   16'h1234, 16'h1235, 1'b0, 3'b001, 3'b010, 4);
    runOne("eq casc110",  16'hABCD, 16'hABCD, 1'b1, 3'b110, 3'b110, 4);
    runOne("mid chunk",   16'h1A00, 16'h1B00, 1'b0, 3'b001, 3'b010, 2);
    runOne("s pos>neg",   16'h0001, 16'hFF00, 1'b1, 3'b001, 3'b100, 1);

    // start held while busy is ignored: exactly one done.
    @(negedge clk);
    driveReq(16'h5555, 16'h5555, 1'b0, 3'b001);
    @(negedge clk);
    bus.iData_a = 16'h0000; bus.iData_b = 16'hFFFF;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done === 1'b1) nd++;
      @(negedge clk);
    end
    check("busy start dones", 32'(nd), 32'd1);
    check("busy start out", 32'(bus.oData), 32'h1);

    // Back to back: new start in the done cycle.
    runOne("b2b first", 16'h1234, 16'h1234, 1'b0, 3'b001, 3'b001, 4);
    driveReq(16'h0001, 16'h0002, 1'b0, 3'b001);
    @(negedge clk);
    waitDone("b2b second", lat);
    check("b2b second lat", 32'(lat), 32'd4);
    check("b2b second out", 32'(bus.oData), 32'h2);

    // Reset two cycles into an equal-operand compare.
    @(negedge clk);
    driveReq(16'h5555, 16'h5555, 1'b0, 3'b100);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid busy",  32'(bus.busy),  32'd0);
    check("rst mid done",  32'(bus.done),  32'd0);
    check("rst mid oData", 32'(bus.oData), 32'd0);
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done === 1'b1) nd++;
      @(negedge clk);
    end
    check("rst mid no done", 32'(nd), 32'd0);
    runOne("after rst", 16'h0F00, 16'h0E00, 1'b0, 3'b001, 3'b100, 2);

    // rst wins over start in the same cycle.
    @(negedge clk);
    rst = 1'b1;
    driveReq(16'h0001, 16'h0002, 1'b0, 3'b001);
    @(negedge clk);
    check("rst+start busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    runOne("final", 16'h7FFF, 16'h8000, 1'b1, 3'b001, 3'b100, 1);

    @(negedge clk);
    chkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
